gt1_rom_loader: RTL and testbench

- Sequential consumer of the Gigatron option ROM.
- Walks a GT1 program image byte-by-byte from the ROM, parses GT1 segment records and emits one RAM write per payload byte over a valid/ready handshake to the Gigatron RAM-load port.
- On the terminator, captures the GT1 execution address and reports done, so the system can jump to the loaded program.

---
 rtl/gt1_rom_loader_if.sv | 28 ++
 rtl/gt1_rom_loader.sv | 198 +++++++++++++++++++
 tb/tb_gt1_rom_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gt1_rom_loader_if.sv
// Loader-side bus bundle: option-ROM fetch port plus the RAM-load
// valid/ready write channel.
interface gt1_rom_loader_if;
  logic [15:0] rom_address;
  logic [7:0]  rom_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_address;
  logic [7:0]  wr_data;

  modport master (
    output rom_address,
    input  rom_data,
    output wr_valid,
    input  wr_ready,
    output wr_address,
    output wr_data
  );

  modport slave (
    input  rom_address,
    output rom_data,
    input  wr_valid,
    output wr_ready,
    input  wr_address,
    input  wr_data
  );
endinterface

// File: rtl/gt1_rom_loader.sv
// Walks a GT1 image in the option ROM, replays each segment payload as RAM
// writes and captures the execution address from the terminator record.
module gt1_rom_loader #(
  parameter logic [15:0] ROM_BASE    = 16'd0,
  parameter logic [15:0] ROM_LAST    = 16'd9866,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      exec_address,
  gt1_rom_loader_if.master bus
);
  localparam logic [1:0] LAT = 2'(ROM_LATENCY);

  typedef enum logic [3:0] {
    IDLE, FETCH_HI, FETCH_LO, FETCH_LEN, DATA_FETCH, DATA_WRITE,
    EXEC_HI, EXEC_LO, DONE, ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        first_q, first_d;
  logic [7:0]  seg_hi_q, seg_hi_d;
  logic [7:0]  seg_lo_q, seg_lo_d;
  logic [8:0]  count_q, count_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] exec_q, exec_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic       fetching_s, out_of_range_s, byte_ok_s;
  logic [8:0] len_s;
  logic [9:0] seg_end_s;

  assign fetching_s     = (state_q == FETCH_HI) || (state_q == FETCH_LO) ||
                          (state_q == FETCH_LEN) || (state_q == DATA_FETCH) ||
                          (state_q == EXEC_HI) || (state_q == EXEC_LO);
  assign out_of_range_s = (ptr_q > ROM_LAST);
  // rom_data is trusted only once the address has been held for LAT cycles
  assign byte_ok_s      = fetching_s && !out_of_range_s && (wcnt_q == LAT);
  assign len_s          = (bus.rom_data == 8'd0) ? 9'd256 : {1'b0, bus.rom_data};
  assign seg_end_s      = {2'b00, seg_lo_q} + {1'b0, len_s};

  // Next-state, fetch sequencing and write-channel logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wcnt_d     = wcnt_q;
    first_d    = first_q;
    seg_hi_d   = seg_hi_q;
    seg_lo_d   = seg_lo_q;
    count_d    = count_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    exec_d     = exec_q;

    if (fetching_s && !out_of_range_s && (wcnt_q != LAT)) begin
      wcnt_d = wcnt_q + 2'd1;
    end else if (byte_ok_s) begin
      wcnt_d = 2'd0;
      ptr_d  = ptr_q + 16'd1;
    end else begin
      wcnt_d = 2'd0;
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = FETCH_HI;
          ptr_d   = ROM_BASE;
          first_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      FETCH_HI, FETCH_LO, FETCH_LEN, DATA_FETCH, EXEC_HI, EXEC_LO: begin
        if (out_of_range_s) begin
          state_d = ERROR;
        end else if (!byte_ok_s) begin
          state_d = state_q;
        end else begin
          case (state_q)
            FETCH_HI: begin
              // a zero high byte only terminates after the first record
              if ((bus.rom_data == 8'd0) && !first_q) begin
                state_d = EXEC_HI;
              end else begin
                seg_hi_d = bus.rom_data;
                state_d  = FETCH_LO;
              end
            end
            FETCH_LO: begin
              seg_lo_d = bus.rom_data;
              state_d  = FETCH_LEN;
            end
            FETCH_LEN: begin
              if (seg_end_s > 10'd256) begin
                state_d = ERROR;
              end else begin
                count_d = len_s;
                state_d = DATA_FETCH;
              end
            end
            DATA_FETCH: begin
              wr_valid_d = 1'b1;
              wr_addr_d  = {seg_hi_q, seg_lo_q};
              wr_data_d  = bus.rom_data;
              state_d    = DATA_WRITE;
            end
            EXEC_HI: begin
              exec_d[15:8] = bus.rom_data;
              state_d      = EXEC_LO;
            end
            EXEC_LO: begin
              exec_d[7:0] = bus.rom_data;
              state_d     = DONE;
            end
            default: state_d = ERROR;
          endcase
        end
      end
      DATA_WRITE: begin
        if (bus.wr_ready) begin
          wr_valid_d = 1'b0;
          seg_lo_d   = seg_lo_q + 8'd1;
          count_d    = count_q - 9'd1;
          if (count_q == 9'd1) begin
            first_d = 1'b0;
            state_d = FETCH_HI;
          end else begin
            state_d = DATA_FETCH;
          end
        end else begin
          state_d = DATA_WRITE;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  // Status flags follow the state being entered so they register with it.
  always_comb begin
    busy_d  = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= ROM_BASE;
      wcnt_q     <= 2'd0;
      first_q    <= 1'b1;
      seg_hi_q   <= 8'd0;
      seg_lo_q   <= 8'd0;
      count_q    <= 9'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
      exec_q     <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      first_q    <= first_d;
      seg_hi_q   <= seg_hi_d;
      seg_lo_q   <= seg_lo_d;
      count_q    <= count_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      exec_q     <= exec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.rom_address = ptr_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_address  = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign exec_address    = exec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
endmodule

// File: tb/tb_gt1_rom_loader.sv
// Scoreboard bench: a GT1 parser model predicts every RAM write and the final
// status; monitors pop and compare whenever a write handshake completes.
module tb_gt1_rom_loader;
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, error0, busy1, done1, error1;
  logic [15:0] exec0, exec1;
  logic rdy0, rdy1;
  logic [7:0] rom_mem [0:1023];
  logic [7:0] r0, r1a, r1b;

  int checks = 0, failures = 0;
  int cyc = 0;
  wr_t q0[$], q1[$];
  int acc0 = 0, acc1 = 0, stall0 = 0, stall_cnt = 0, last_acc_cyc = 0;
  int rdy_mode = 0;
  bit mon_en = 1'b1, tput_en = 1'b0;
  bit hold_v = 1'b0;
  logic [15:0] hold_a;
  logic [7:0]  hold_d;

  gt1_rom_loader_if bus0 ();
  gt1_rom_loader_if bus1 ();

  gt1_rom_loader #(.ROM_BASE(16'd0), .ROM_LAST(16'd9866), .ROM_LATENCY(1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .error(error0), .exec_address(exec0), .bus(bus0));

  gt1_rom_loader #(.ROM_BASE(16'd0), .ROM_LAST(16'd4), .ROM_LATENCY(2)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .error(error1), .exec_address(exec1), .bus(bus1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ROM models: one-stage for dut0, two-stage for dut1.
  always @(posedge clock) begin
    r0  <= rom_mem[bus0.rom_address[9:0]];
    r1a <= rom_mem[bus1.rom_address[9:0]];
    r1b <= r1a;
  end
  assign bus0.rom_data = r0;
  assign bus1.rom_data = r1b;
  assign bus0.wr_ready = rdy0;
  assign bus1.wr_ready = rdy1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rb(input int p);
    return rom_mem[p[9:0]];
  endfunction

  // Reference parser: walks the image with plain arithmetic and pushes the
  // writes a correct loader must make; ok=0 means the load must end in error.
  task automatic model(input int last, input int d, output bit ok,
                       output logic [15:0] ex, output int nw);
    int p, hi, lo, n;
    bit first;
    wr_t w;
    p = 0; first = 1'b1; ok = 1'b0; ex = 16'h0; nw = 0;
    for (int r = 0; r < 64; r++) begin
      if (p > last) return;
      hi = rb(p); p++;
      if (!first && hi == 0) begin
        if (p + 1 > last) return;
        ex = {rb(p), rb(p + 1)};
        ok = 1'b1;
        return;
      end
      if (p + 1 > last) return;
      lo = rb(p); n = rb(p + 1); p += 2;
      if (n == 0) n = 256;
      if (lo + n > 256) return;
      for (int i = 0; i < n; i++) begin
        if (p > last) return;
        w.a = {8'(hi), 8'(lo + i)};
        w.d = rb(p);
        if (d == 0) q0.push_back(w); else q1.push_back(w);
        nw++; p++;
      end
      first = 1'b0;
    end
  endtask

  task automatic load_img(input logic [7:0] img [$]);
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'h00;
    for (int i = 0; i < img.size(); i++) rom_mem[i] = img[i];
  endtask

  task automatic gen_random();
    logic [7:0] img [$];
    int nrec, hi, lo, n;
    nrec = $urandom_range(1, 4);
    for (int r = 0; r < nrec; r++) begin
      hi = (r == 0) ? $urandom_range(0, 255) : $urandom_range(1, 255);
      n  = $urandom_range(1, 40);
      lo = $urandom_range(0, 255);
      if ($urandom_range(0, 5) != 0 && lo + n > 256) lo = 256 - n;
      img.push_back(8'(hi));
      img.push_back(8'(lo));
      img.push_back(8'(n));
      for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
    end
    img.push_back(8'h00);
    img.push_back(8'($urandom_range(0, 255)));
    img.push_back(8'($urandom_range(0, 255)));
    load_img(img);
  endtask

  // Runs one load on dut d; poke>0 re-pulses start mid-load (must be ignored).
  task automatic run_load(input int d, input int poke);
    bit ok, fin;
    logic [15:0] ex;
    int nw;
    model((d == 0) ? 9866 : 4, d, ok, ex, nw);
    acc0 = 0; acc1 = 0; stall0 = 0; stall_cnt = 0;
    @(negedge clock);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 5000 && !fin; c++) begin
      start0 = (poke > 0 && c == poke && d == 0);
      @(negedge clock);
      fin = (d == 0) ? (done0 || error0) : (done1 || error1);
    end
    start0 = 1'b0;
    chk("load_finished", 32'(fin), 32'd1);
    if (d == 0) begin
      chk("done", 32'(done0), 32'(ok));
      chk("error", 32'(error0), 32'(!ok));
      chk("busy_after", 32'(busy0), 32'd0);
      if (ok) chk("exec_address", 32'(exec0), 32'(ex));
      chk("write_count", 32'(acc0), 32'(nw));
      chk("queue_drained", 32'(q0.size()), 32'd0);
    end else begin
      chk("dut1_done", 32'(done1), 32'(ok));
      chk("dut1_error", 32'(error1), 32'(!ok));
      chk("dut1_busy_after", 32'(busy1), 32'd0);
      chk("dut1_write_count", 32'(acc1), 32'(nw));
      chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
    end
    q0.delete(); q1.delete();
  endtask

  // wr_ready driver for dut0.
  initial begin
    rdy0 = 1'b1; rdy1 = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (rdy_mode)
        1: rdy0 = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus0.wr_valid && acc0 == 1 && stall_cnt < 5) begin
            rdy0 = 1'b0; stall_cnt++;
          end else rdy0 = 1'b1;
        end
        3: rdy0 = (acc0 < 1);
        default: rdy0 = 1'b1;
      endcase
    end
  end

  // dut0 monitor: scoreboard pop on handshake, stall stability, throughput.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (bus0.wr_valid) begin
        if (hold_v) begin
          chk("stall_addr_stable", 32'(bus0.wr_address), 32'(hold_a));
          chk("stall_data_stable", 32'(bus0.wr_data), 32'(hold_d));
        end
        if (bus0.wr_ready) begin
          if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: got %0h=%0h expected none",
                     bus0.wr_address, bus0.wr_data);
          end else begin
            wr_t e;
            e = q0.pop_front();
            chk("write", {8'h00, bus0.wr_address, bus0.wr_data}, {8'h00, e.a, e.d});
          end
          if (tput_en && acc0 > 0) chk("throughput_gap", 32'(cyc - last_acc_cyc), 32'd3);
          last_acc_cyc = cyc;
          acc0++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1; hold_a = bus0.wr_address; hold_d = bus0.wr_data;
          stall0++;
        end
      end else begin
        if (hold_v) chk("valid_held_in_stall", 32'(bus0.wr_valid), 32'd1);
        hold_v = 1'b0;
      end
    end else hold_v = 1'b0;
  end

  // dut1 monitor.
  always @(negedge clock) begin
    if (mon_en && !reset && bus1.wr_valid && bus1.wr_ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_write: got %0h=%0h expected none",
                 bus1.wr_address, bus1.wr_data);
      end else begin
        wr_t e;
        e = q1.pop_front();
        chk("dut1_write", {8'h00, bus1.wr_address, bus1.wr_data}, {8'h00, e.a, e.d});
      end
      acc1++;
    end
  end

  initial begin
    logic [7:0] img_a [$] = '{8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h02, 8'h00};
    logic [7:0] img_b [$] = '{8'h00, 8'h30, 8'h02, 8'h11, 8'h22, 8'h00, 8'h03, 8'h00};
    logic [7:0] img_c [$];
    logic [7:0] img_d [$] = '{8'h02, 8'hFE, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h02, 8'h00};
    logic [7:0] img_e [$] = '{8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    bit ok, seen;
    logic [15:0] ex;
    int nw;

    load_img(img_a);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_error", 32'(error0), 32'd0);
    chk("rst_wr_valid", 32'(bus0.wr_valid), 32'd0);
    chk("rst_wr_address", 32'(bus0.wr_address), 32'd0);
    chk("rst_wr_data", 32'(bus0.wr_data), 32'd0);
    chk("rst_exec", 32'(exec0), 32'd0);
    chk("rst_rom_address", 32'(bus0.rom_address), 32'd0);

    tput_en = 1'b1;
    run_load(0, 0);
    tput_en = 1'b0;
    load_img(img_b);
    run_load(0, 0);

    img_c = '{8'h80, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) img_c.push_back(8'(i));
    img_c.push_back(8'h00); img_c.push_back(8'h80); img_c.push_back(8'h00);
    load_img(img_c);
    tput_en = 1'b1;
    run_load(0, 100);
    tput_en = 1'b0;

    load_img(img_d);
    run_load(0, 0);

    load_img(img_a);
    rdy_mode = 2;
    run_load(0, 0);
    chk("stall_cycles", 32'(stall0), 32'd5);
    rdy_mode = 0;

    load_img(img_e);
    run_load(1, 0);

    // Reset while the second write is stalled, then reload cleanly.
    load_img(img_a);
    model(9866, 0, ok, ex, nw);
    acc0 = 0;
    rdy_mode = 3;
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clock);
      seen = bus0.wr_valid && (bus0.wr_address == 16'h0201);
    end
    chk("second_write_reached", 32'(seen), 32'd1);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_error", 32'(error0), 32'd0);
    chk("abort_wr_valid", 32'(bus0.wr_valid), 32'd0);
    chk("abort_wr_address", 32'(bus0.wr_address), 32'd0);
    chk("abort_wr_data", 32'(bus0.wr_data), 32'd0);
    chk("abort_exec", 32'(exec0), 32'd0);
    chk("abort_rom_address", 32'(bus0.rom_address), 32'd0);
    reset = 1'b0;
    rdy_mode = 0;
    q0.delete();
    @(negedge clock);
    mon_en = 1'b1;
    run_load(0, 0);

    rdy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      gen_random();
      run_load(0, 0);
    end
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
